// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared widths and requester indices for the register-bank write arbiter.
package arbitro_escritura_banco_pkg;
  localparam int ANCHO     = 32;
  localparam int ANCHO_DIR = 5;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/arbitro_escritura_banco_if.sv
// Requester A/B write ports plus the registered bank write port and busy flag.
interface arbitro_escritura_banco_if
  import arbitro_escritura_banco_pkg::*;
#(
  parameter int AW = ANCHO,
  parameter int DW = ANCHO_DIR
);
  logic          val_a;
  logic [DW-1:0] dir_a;
  logic [AW-1:0] di_a;
  logic          listo_a;
  logic          val_b;
  logic [DW-1:0] dir_b;
  logic [AW-1:0] di_b;
  logic          listo_b;
  logic [DW-1:0] dir;
  logic [AW-1:0] di;
  logic          ena;
  logic          ocupado;

  modport master (
    output val_a, dir_a, di_a, val_b, dir_b, di_b,
    input  listo_a, listo_b, dir, di, ena, ocupado
  );

  modport slave (
    input  val_a, dir_a, di_a, val_b, dir_b, di_b,
    output listo_a, listo_b, dir, di, ena, ocupado
  );
endinterface

// File: rtl/arbitro_escritura_banco_retencion_escritura.sv
// One-entry holding register per requester; ready whenever empty or being drained this cycle.
module retencion_escritura #(
  parameter int ANCHO     = 32,
  parameter int ANCHO_DIR = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 val,
  input  logic [ANCHO_DIR-1:0] dir_nuevo,
  input  logic [ANCHO-1:0]     di_nuevo,
  input  logic                 concedido,
  output logic                 listo,
  output logic                 lleno,
  output logic [ANCHO_DIR-1:0] dir_ret,
  output logic [ANCHO-1:0]     di_ret
);
  logic captura;

  assign listo   = !reset && (!lleno || concedido);
  assign captura = val && listo;

  always_ff @(posedge clk) begin
    if (reset) begin
      lleno <= 1'b0;
    end else if (captura) begin
      lleno <= 1'b1;
    end else if (concedido) begin
      lleno <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while lleno is set.
  always_ff @(posedge clk) begin
    if (captura) begin
      dir_ret <= dir_nuevo;
      di_ret  <= di_nuevo;
    end
  end
endmodule

// File: rtl/arbitro_escritura_banco.sv
// Two-requester round-robin write arbiter for a register bank, registered write port.
// Optional ARBITRO_PROTEGE_R0_EN: writes to register 0 are granted but issued with ena low.
module arbitro_escritura_banco
  import arbitro_escritura_banco_pkg::*;
#(
  parameter int ANCHO     = arbitro_escritura_banco_pkg::ANCHO,
  parameter int ANCHO_DIR = arbitro_escritura_banco_pkg::ANCHO_DIR
) (
  input logic clk,
  input logic reset,
  arbitro_escritura_banco_if.slave bus
);
  logic                 lleno_a, lleno_b;
  logic                 gnt_a, gnt_b, gnt;
  logic [ANCHO_DIR-1:0] dir_ret_a, dir_ret_b, dir_sel;
  logic [ANCHO-1:0]     di_ret_a, di_ret_b, di_sel;
  logic                 turno;
  logic                 escribe;

  retencion_escritura #(.ANCHO(ANCHO), .ANCHO_DIR(ANCHO_DIR)) u_ret_a (
    .clk(clk), .reset(reset), .val(bus.val_a), .dir_nuevo(bus.dir_a),
    .di_nuevo(bus.di_a), .concedido(gnt_a), .listo(bus.listo_a),
    .lleno(lleno_a), .dir_ret(dir_ret_a), .di_ret(di_ret_a)
  );

  retencion_escritura #(.ANCHO(ANCHO), .ANCHO_DIR(ANCHO_DIR)) u_ret_b (
    .clk(clk), .reset(reset), .val(bus.val_b), .dir_nuevo(bus.dir_b),
    .di_nuevo(bus.di_b), .concedido(gnt_b), .listo(bus.listo_b),
    .lleno(lleno_b), .dir_ret(dir_ret_b), .di_ret(di_ret_b)
  );

  // Contention is settled by the turn pointer; a lone full entry always wins.
  always_comb begin
    gnt_a   = lleno_a && (!lleno_b || turno == REQ_A);
    gnt_b   = lleno_b && (!lleno_a || turno == REQ_B);
    gnt     = gnt_a || gnt_b;
    dir_sel = gnt_b ? dir_ret_b : dir_ret_a;
    di_sel  = gnt_b ? di_ret_b  : di_ret_a;
`ifdef ARBITRO_PROTEGE_R0_EN
    escribe = gnt && (dir_sel != '0);
`else
    escribe = gnt;
`endif
  end

  assign bus.ocupado = lleno_a || lleno_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      turno   <= REQ_A;
      bus.ena <= 1'b0;
      bus.dir <= '0;
      bus.di  <= '0;
    end else begin
      bus.ena <= escribe;
      if (lleno_a && lleno_b) begin
        turno <= gnt_a ? REQ_B : REQ_A;
      end
      if (gnt) begin
        bus.dir <= dir_sel;
        bus.di  <= di_sel;
      end
    end
  end
endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed bench for arbitro_escritura_banco with a small register-bank model.
module tb_arbitro_escritura_banco;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [31:0] bank [32];

  arbitro_escritura_banco_if bus ();

  arbitro_escritura_banco dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ena) bank[bus.dir] <= bus.di;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.val_a = 1'b0;
    bus.val_b = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    reset = 1'b1;
    bus.val_a = 1'b1; bus.dir_a = 5'd9; bus.di_a = 32'h55;
    bus.val_b = 1'b1; bus.dir_b = 5'd8; bus.di_b = 32'h66;
    tick();
    chk("rst_listo_a", {31'b0, bus.listo_a}, 32'd0);
    chk("rst_listo_b", {31'b0, bus.listo_b}, 32'd0);
    tick();
    chk("rst_ena", {31'b0, bus.ena}, 32'd0);
    chk("rst_dir", {27'b0, bus.dir}, 32'd0);
    chk("rst_di", bus.di, 32'd0);
    chk("rst_ocupado", {31'b0, bus.ocupado}, 32'd0);
    idle();
    reset = 1'b0;
    tick();
    chk("rst_no_write", {31'b0, bus.ena}, 32'd0);

    // A alone: one-cycle request, write appears the cycle after capture.
    bus.val_a = 1'b1; bus.dir_a = 5'd3; bus.di_a = 32'h0000_00AA;
    #1;
    chk("a_listo_empty", {31'b0, bus.listo_a}, 32'd1);
    tick();
    idle();
    chk("a_ena_capture", {31'b0, bus.ena}, 32'd0);
    chk("a_ocupado", {31'b0, bus.ocupado}, 32'd1);
    tick();
    chk("a_ena", {31'b0, bus.ena}, 32'd1);
    chk("a_dir", {27'b0, bus.dir}, 32'd3);
    chk("a_di", bus.di, 32'hAA);
    chk("a_ocupado_clr", {31'b0, bus.ocupado}, 32'd0);
    tick();
    chk("a_ena_off", {31'b0, bus.ena}, 32'd0);
    chk("a_dir_hold", {27'b0, bus.dir}, 32'd3);

    // A and B together: A first (reset pointer), B one cycle later.
    bus.val_a = 1'b1; bus.dir_a = 5'd4; bus.di_a = 32'h11;
    bus.val_b = 1'b1; bus.dir_b = 5'd5; bus.di_b = 32'h22;
    tick();
    idle();
    chk("ab_listo_b_low", {31'b0, bus.listo_b}, 32'd0);
    chk("ab_listo_a", {31'b0, bus.listo_a}, 32'd1);
    tick();
    chk("ab_ena1", {31'b0, bus.ena}, 32'd1);
    chk("ab_dir1", {27'b0, bus.dir}, 32'd4);
    chk("ab_di1", bus.di, 32'h11);
    chk("ab_listo_b_back", {31'b0, bus.listo_b}, 32'd1);
    tick();
    chk("ab_ena2", {31'b0, bus.ena}, 32'd1);
    chk("ab_dir2", {27'b0, bus.dir}, 32'd5);
    chk("ab_di2", bus.di, 32'h22);
    tick();
    chk("ab_ena_off", {31'b0, bus.ena}, 32'd0);

    // Both continuously requesting: strict alternation A,B,A,B...
    pulse_reset();
    bus.val_a = 1'b1; bus.dir_a = 5'd1; bus.di_a = 32'hA1;
    bus.val_b = 1'b1; bus.dir_b = 5'd2; bus.di_b = 32'hB2;
    #1;
    chk("rr_listo_a0", {31'b0, bus.listo_a}, 32'd1);
    chk("rr_listo_b0", {31'b0, bus.listo_b}, 32'd1);
    tick();
    chk("rr_listo_a1", {31'b0, bus.listo_a}, 32'd1);
    chk("rr_listo_b1", {31'b0, bus.listo_b}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_ena", {31'b0, bus.ena}, 32'd1);
      chk("rr_dir", {27'b0, bus.dir}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_di", bus.di, (i % 2 == 0) ? 32'hA1 : 32'hB2);
      chk("rr_listo_a", {31'b0, bus.listo_a}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_listo_b", {31'b0, bus.listo_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Same destination from both: A then B, B's data lands last.
    pulse_reset();
    bus.val_a = 1'b1; bus.dir_a = 5'd7; bus.di_a = 32'h1;
    bus.val_b = 1'b1; bus.dir_b = 5'd7; bus.di_b = 32'h2;
    tick();
    idle();
    tick();
    chk("same_di1", bus.di, 32'h1);
    chk("same_ena1", {31'b0, bus.ena}, 32'd1);
    tick();
    chk("same_di2", bus.di, 32'h2);
    chk("same_dir2", {27'b0, bus.dir}, 32'd7);
    tick();
    chk("same_bank_r7", bank[7], 32'h2);

    // Reset while both entries are full discards them.
    bus.val_a = 1'b1; bus.dir_a = 5'd12; bus.di_a = 32'hC1;
    bus.val_b = 1'b1; bus.dir_b = 5'd13; bus.di_b = 32'hC2;
    tick();
    idle();
    chk("mid_ocupado", {31'b0, bus.ocupado}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_listo_a", {31'b0, bus.listo_a}, 32'd0);
    chk("mid_listo_b", {31'b0, bus.listo_b}, 32'd0);
    tick();
    chk("mid_ena", {31'b0, bus.ena}, 32'd0);
    chk("mid_ocupado_clr", {31'b0, bus.ocupado}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_no_write", {31'b0, bus.ena}, 32'd0);
    tick();
    chk("mid_bank_r12", bank[12], 32'h0);

    // Register 0 write.
    bus.val_a = 1'b1; bus.dir_a = 5'd0; bus.di_a = 32'hFF;
    tick();
    idle();
    tick();
`ifdef ARBITRO_PROTEGE_R0_EN
    chk("r0_ena", {31'b0, bus.ena}, 32'd0);
    chk("r0_bank", bank[0], 32'h0);
`else
    chk("r0_ena", {31'b0, bus.ena}, 32'd1);
    chk("r0_dir", {27'b0, bus.dir}, 32'd0);
    chk("r0_di", bus.di, 32'hFF);
`endif
    chk("r0_ocupado", {31'b0, bus.ocupado}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_escritura_banco.md
ARBITRO_ESCRITURA_BANCO -- requirements
Module: arbitro_escritura_banco

Interface
REQ-001 Parameter ANCHO, 32, data width of register-bank write data.
REQ-002 Parameter ANCHO_DIR, 5, register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 val_a  input  1  requester A (ALU writeback) write request valid.
REQ-006 dir_a  input  ANCHO_DIR  requester A destination register.
REQ-007 di_a  input  ANCHO  requester A write data.
REQ-008 listo_a  output  1  A request accepted this cycle when val_a && listo_a.
REQ-009 val_b, dir_b, di_b, listo_b SHALL mirror REQ-005..REQ-008 for requester B (load unit).
REQ-010 dir  output  ANCHO_DIR  register-bank write address, registered.
REQ-011 di  output  ANCHO  register-bank write data, registered.
REQ-012 ena  output  1  register-bank write enable, registered, high one cycle per write.
REQ-013 ocupado  output  1  high while either holding register is full.

Function
REQ-014 Each requester SHALL own a one-entry holding register (full flag, dir, data).
- Capture: val_x && listo_x at edge captures dir_x/di_x, sets full_x.
REQ-015 listo_x SHALL be combinational: !full_x || (full_x granted this cycle); single requester sustains one write per cycle.
REQ-016 Arbitration each cycle among full holding registers: one full -> grant it; both full -> round-robin.
REQ-017 Round-robin pointer SHALL flip to the other requester after each grant made while both were full; reset value favours A.
REQ-018 Grant at edge loads dir/di from granted holding register, sets ena=1, clears that full flag (unless same edge recaptures).
REQ-019 No grant -> ena=0 next cycle; dir/di hold previous values.
REQ-020 Latency: request accepted at edge N -> ena=1 with its data during cycle N+1 to N+2 (one cycle after capture) when uncontested; contested loser delayed exactly one further cycle.
REQ-021 Same dir from A and B: issued in grant order, both writes performed; last grant wins in bank.
REQ-022 ocupado = full_a || full_b.
REQ-023 Requests are never dropped or reordered per requester; at most two writes in flight.

Reset
REQ-024 While reset high at edge: full_a=full_b=0, ena=0, dir=0, di=0, pointer=A.
REQ-025 listo_a and listo_b SHALL be 0 while reset is high; requests presented then are ignored.
REQ-026 Reset mid-operation SHALL discard held requests with no write issued.

Configuration
REQ-027 Macro ARBITRO_PROTEGE_R0_EN defined: write to dir 0 SHALL be accepted and granted normally but issued with ena=0 (register 0 stays constant).
REQ-028 Macro undefined: dir 0 writes issued like any other address.

Structure
REQ-029 Shared package holds ANCHO, ANCHO_DIR defaults and requester index constants REQ_A=0, REQ_B=1.
REQ-030 One sub-module retencion_escritura (holding register + listo logic) SHALL be instantiated twice.

Verification
REQ-031 A only: dir_a=3, di_a=0x0000_00AA one cycle -> next cycle ena=1, dir=3, di=0xAA; then ena=0.
REQ-032 A and B same cycle, dir 4/5, data 0x11/0x22 -> ena two consecutive cycles: dir 4 then dir 5; listo_b=0 one cycle.
REQ-033 Both continuous for 6 cycles -> grants alternate A,B,A,B...; no requester starves; each listo high every other cycle.
REQ-034 A and B both dir 7, data 0x1/0x2 simultaneously -> writes issued A then B; final bank r7=0x2.
REQ-035 Reset asserted while both full -> next cycle ena=0, ocupado=0, listo_a=listo_b=0 during reset.
REQ-036 dir_a=0, di_a=0xFF -> ena=0 with ARBITRO_PROTEGE_R0_EN defined; ena=1, dir=0 without it.
